// File: rtl/mfp_srec_ahb_write_engine.sv
// Coalesces SREC byte writes into masked words, buffers them, and issues AHB-Lite single writes.
// Optional build macro MFP_SREC_AHB_ERRCNT_EN enables the saturating AHB error counter.
module mfp_srec_ahb_write_engine #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        big_endian,
  input  logic        in_progress,
  input  logic [31:0] write_address,
  input  logic [7:0]  write_byte,
  input  logic        write_enable,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] error_count
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef struct packed {
    logic        be;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  function automatic logic [4:0] lane_shift(input logic [1:0] lane, input logic be);
    lane_shift = be ? {~lane, 3'b000} : {lane, 3'b000};
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] data, input logic [7:0] b,
                                           input logic [1:0] lane, input logic be);
    logic [4:0] sh;
    sh = lane_shift(lane, be);
    put_byte = (data & ~(32'h0000_00FF << sh)) | ({24'h0, b} << sh);
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] data, input logic [1:0] lane,
                                          input logic be);
    logic [31:0] t;
    t = data >> lane_shift(lane, be);
    get_byte = t[7:0];
  endfunction

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    if (m[0])      low_lane = 2'd0;
    else if (m[1]) low_lane = 2'd1;
    else if (m[2]) low_lane = 2'd2;
    else if (m[3]) low_lane = 2'd3;
    else           low_lane = 2'd0;
  endfunction

  // Coalesce buffer and flush control
  logic [29:0] buf_addr, buf_addr_n;
  logic [31:0] buf_data, buf_data_n;
  logic [3:0]  buf_mask, buf_mask_n;
  logic        buf_valid, buf_valid_n;
  logic        flush_req, flush_req_n, in_prog_d;
  logic        push;
  entry_t      push_e;
  logic [3:0]  in_oh, m_mask;
  logic [31:0] m_data;
  logic        in_fall;

  assign in_fall = in_prog_d & ~in_progress;
  assign in_oh   = 4'b0001 << write_address[1:0];

  always_comb begin
    buf_addr_n  = buf_addr;
    buf_data_n  = buf_data;
    buf_mask_n  = buf_mask;
    buf_valid_n = buf_valid;
    flush_req_n = flush_req | in_fall;
    push        = 1'b0;
    push_e      = '{be: big_endian, addr: buf_addr, data: buf_data, mask: buf_mask};
    m_data      = put_byte(buf_valid ? buf_data : 32'h0, write_byte, write_address[1:0], big_endian);
    m_mask      = (buf_valid ? buf_mask : 4'h0) | in_oh;
    if (write_enable) begin
      if (buf_valid && (buf_addr != write_address[31:2])) begin
        push        = 1'b1;
        buf_addr_n  = write_address[31:2];
        buf_data_n  = put_byte(32'h0, write_byte, write_address[1:0], big_endian);
        buf_mask_n  = in_oh;
        buf_valid_n = 1'b1;
      end else if (m_mask == 4'hF) begin
        push        = 1'b1;
        push_e      = '{be: big_endian, addr: write_address[31:2], data: m_data, mask: m_mask};
        buf_mask_n  = 4'h0;
        buf_valid_n = 1'b0;
      end else begin
        buf_addr_n  = write_address[31:2];
        buf_data_n  = m_data;
        buf_mask_n  = m_mask;
        buf_valid_n = 1'b1;
      end
    end else if (flush_req) begin
      push        = buf_valid;
      buf_mask_n  = 4'h0;
      buf_valid_n = 1'b0;
      flush_req_n = in_fall;
    end
  end

  always_ff @(posedge HCLK) begin
    buf_addr <= buf_addr_n;
    buf_data <= buf_data_n;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      buf_mask  <= 4'h0;
      buf_valid <= 1'b0;
      flush_req <= 1'b0;
      in_prog_d <= 1'b0;
    end else begin
      buf_mask  <= buf_mask_n;
      buf_valid <= buf_valid_n;
      flush_req <= flush_req_n;
      in_prog_d <= in_progress;
    end
  end

  // Entry FIFO
  entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            fifo_ne, push_ok, pop;
  entry_t          pop_e;

  assign fifo_ne = (count != '0);
  assign push_ok = push & ((count != DEPTH_C) | pop);
  assign pop_e   = mem[rd_ptr];

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wr_ptr] <= push_e;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // AHB master: working entry, lanes are retired only when their data phase completes
  logic [1:0]  state;
  logic        work_be, work_full;
  logic [29:0] work_addr;
  logic [31:0] work_data;
  logic [3:0]  work_mask, rest_mask;
  logic [1:0]  lane_sel;
  logic        more;

  assign lane_sel  = low_lane(work_mask);
  assign rest_mask = work_mask & ~(4'b0001 << lane_sel);
  assign more      = ~work_full & (rest_mask != 4'h0);
  assign pop       = fifo_ne & ((state == ST_IDLE) | ((state == ST_DATA) & HREADY & ~more));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      work_be   <= 1'b0;
      work_full <= 1'b0;
      work_addr <= 30'h0;
      work_data <= 32'h0;
      work_mask <= 4'h0;
    end else begin
      case (state)
        ST_IDLE: if (pop) state <= ST_ADDR;
        ST_ADDR: if (HREADY) state <= ST_DATA;
        ST_DATA: if (HREADY) begin
          if (more) begin
            state     <= ST_ADDR;
            work_mask <= rest_mask;
          end else if (pop) begin
            state <= ST_ADDR;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (pop) begin
        work_be   <= pop_e.be;
        work_full <= (pop_e.mask == 4'hF);
        work_addr <= pop_e.addr;
        work_data <= pop_e.data;
        work_mask <= pop_e.mask;
      end
    end
  end

  assign HTRANS    = (state == ST_ADDR) ? 2'b10 : 2'b00;
  assign HWRITE    = (state == ST_ADDR);
  assign HSIZE     = work_full ? 3'b010 : 3'b000;
  assign HADDR     = {work_addr, work_full ? 2'b00 : lane_sel};
  assign HWDATA    = work_full ? work_data : {4{get_byte(work_data, lane_sel, work_be)}};
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign busy      = in_progress | flush_req | buf_valid | fifo_ne | (state != ST_IDLE);

`ifdef MFP_SREC_AHB_ERRCNT_EN
  logic [15:0] err_cnt;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) err_cnt <= 16'h0;
    else if ((state == ST_DATA) && HREADY && HRESP && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'h1;
  end
  assign error_count = err_cnt;
`else
  logic unused_hresp;
  assign unused_hresp = HRESP;
  assign error_count  = 16'h0;
`endif

endmodule

// File: tb/tb_mfp_srec_ahb_write_engine.sv
// Directed bench for mfp_srec_ahb_write_engine: default depth instance plus a FIFO_DEPTH=2 instance.
module tb_mfp_srec_ahb_write_engine;
  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        big_endian = 1'b0, in_progress = 1'b0, write_enable = 1'b0;
  logic [31:0] write_address = 32'h0;
  logic [7:0]  write_byte = 8'h0;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, busy, overflow;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [15:0] error_count;

  logic [31:0] s_haddr, s_unused_hwdata;
  logic [2:0]  s_unused_hburst, s_unused_hsize;
  logic        s_unused_hmastlock, s_unused_hwrite, s_busy, s_overflow;
  logic [3:0]  s_unused_hprot;
  logic [1:0]  s_htrans;
  logic [15:0] s_unused_errcnt;

  int total = 0, bad = 0;

  mfp_srec_ahb_write_engine dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .big_endian(big_endian), .in_progress(in_progress),
    .write_address(write_address), .write_byte(write_byte), .write_enable(write_enable),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy), .overflow(overflow), .error_count(error_count));

  mfp_srec_ahb_write_engine #(.FIFO_DEPTH(2)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .big_endian(big_endian), .in_progress(in_progress),
    .write_address(write_address), .write_byte(write_byte), .write_enable(write_enable),
    .HADDR(s_haddr), .HBURST(s_unused_hburst), .HMASTLOCK(s_unused_hmastlock),
    .HPROT(s_unused_hprot), .HSIZE(s_unused_hsize), .HTRANS(s_htrans), .HWDATA(s_unused_hwdata),
    .HWRITE(s_unused_hwrite), .HREADY(HREADY), .HRESP(HRESP), .busy(s_busy),
    .overflow(s_overflow), .error_count(s_unused_errcnt));

  always #5 HCLK = ~HCLK;

  // Transfer monitor: records address phase accepted, then data at data-phase completion
  logic [31:0] mon_addr[$], mon_data[$], s_addr[$];
  logic [2:0]  mon_size[$];
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [2:0]  pend_size = 3'h0;

  always @(negedge HCLK) begin
    if (!HRESETn) pend = 1'b0;
    else begin
      if (pend && HREADY) begin
        mon_addr.push_back(pend_addr);
        mon_data.push_back(HWDATA);
        mon_size.push_back(pend_size);
        pend = 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        pend = 1'b1; pend_addr = HADDR; pend_size = HSIZE;
      end
      if (s_htrans == 2'b10 && HREADY) s_addr.push_back(s_haddr);
    end
  end

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic clear_mon();
    mon_addr.delete(); mon_data.delete(); mon_size.delete(); s_addr.delete();
  endtask

  task automatic send_byte(input logic [31:0] a, input logic [7:0] d);
    write_address = a; write_byte = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!busy && !s_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    tick(); tick();
    total++; if (HADDR !== 32'h0) begin bad++; $display("FAIL rst_haddr got=%h exp=%h", HADDR, 32'h0); end
    total++; if (HWDATA !== 32'h0) begin bad++; $display("FAIL rst_hwdata got=%h exp=%h", HWDATA, 32'h0); end
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL rst_htrans got=%h exp=0", HTRANS); end
    total++; if (HWRITE !== 1'b0) begin bad++; $display("FAIL rst_hwrite got=%b exp=0", HWRITE); end
    total++; if (HSIZE !== 3'b000) begin bad++; $display("FAIL rst_hsize got=%h exp=0", HSIZE); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    total++; if (error_count !== 16'h0) begin bad++; $display("FAIL rst_errcnt got=%h exp=0", error_count); end
    total++; if ({HBURST, HMASTLOCK, HPROT} !== {3'b000, 1'b0, 4'b0011}) begin
      bad++; $display("FAIL rst_const got=%h/%b/%h exp=0/0/3", HBURST, HMASTLOCK, HPROT); end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_le_word();
    bit ok;
    clear_mon();
    big_endian = 1'b0; in_progress = 1'b1; HREADY = 1'b1;
    send_byte(32'h100, 8'h11); send_byte(32'h101, 8'h22);
    send_byte(32'h102, 8'h33); send_byte(32'h103, 8'h44);
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL le_lat_n1 got=%h exp=0", HTRANS); end
    tick();
    total++; if (HTRANS !== 2'b10) begin bad++; $display("FAIL le_lat_n2 got=%h exp=2", HTRANS); end
    total++; if (HADDR !== 32'h100 || HSIZE !== 3'b010 || HWRITE !== 1'b1) begin
      bad++; $display("FAIL le_addr got=%h/%h/%b exp=100/2/1", HADDR, HSIZE, HWRITE); end
    in_progress = 1'b0;
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL le_drain got=timeout exp=idle"); end
    total++; if (mon_addr.size() != 1) begin bad++; $display("FAIL le_count got=%0d exp=1", mon_addr.size()); end
    else if (mon_data[0] !== 32'h44332211 || mon_addr[0] !== 32'h100) begin
      bad++; $display("FAIL le_data got=%h@%h exp=44332211@100", mon_data[0], mon_addr[0]); end
  endtask

  task automatic test_be_word();
    bit ok;
    clear_mon();
    big_endian = 1'b1; in_progress = 1'b1;
    send_byte(32'h100, 8'h11); send_byte(32'h101, 8'h22);
    send_byte(32'h102, 8'h33); send_byte(32'h103, 8'h44);
    in_progress = 1'b0;
    drain(ok);
    big_endian = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL be_drain got=timeout exp=idle"); end
    total++; if (mon_data.size() != 1) begin bad++; $display("FAIL be_count got=%0d exp=1", mon_data.size()); end
    else if (mon_data[0] !== 32'h11223344) begin
      bad++; $display("FAIL be_data got=%h exp=11223344", mon_data[0]); end
  endtask

  task automatic test_flush_bytes();
    bit ok;
    clear_mon();
    in_progress = 1'b1;
    send_byte(32'h201, 8'hAA); send_byte(32'h203, 8'hBB);
    in_progress = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy got=%b exp=1", busy); end
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL flush_drain got=timeout exp=idle"); end
    total++; if (mon_addr.size() != 2) begin bad++; $display("FAIL flush_count got=%0d exp=2", mon_addr.size()); end
    else begin
      total++; if (mon_addr[0] !== 32'h201 || mon_data[0] !== 32'hAAAAAAAA || mon_size[0] !== 3'b000) begin
        bad++; $display("FAIL flush_b0 got=%h/%h/%h exp=201/aaaaaaaa/0", mon_addr[0], mon_data[0], mon_size[0]); end
      total++; if (mon_addr[1] !== 32'h203 || mon_data[1] !== 32'hBBBBBBBB || mon_size[1] !== 3'b000) begin
        bad++; $display("FAIL flush_b1 got=%h/%h/%h exp=203/bbbbbbbb/0", mon_addr[1], mon_data[1], mon_size[1]); end
    end
  endtask

  task automatic test_wait_states();
    bit ok, seen;
    clear_mon();
    in_progress = 1'b1;
    send_byte(32'h300, 8'h01); send_byte(32'h301, 8'h02); send_byte(32'h302, 8'h03);
    HREADY = 1'b0;
    send_byte(32'h303, 8'h04);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (HTRANS == 2'b10) begin seen = 1'b1; break; end
      tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL wait_nonseq got=timeout exp=nonseq"); end
    for (int i = 0; i < 5; i++) begin
      total++; if (HTRANS !== 2'b10 || HADDR !== 32'h300) begin
        bad++; $display("FAIL wait_addr%0d got=%h/%h exp=2/300", i, HTRANS, HADDR); end
      tick();
    end
    HREADY = 1'b1;
    tick();
    HREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (HTRANS !== 2'b00 || HWDATA !== 32'h04030201) begin
        bad++; $display("FAIL wait_data%0d got=%h/%h exp=0/04030201", i, HTRANS, HWDATA); end
      tick();
    end
    HREADY = 1'b1;
    in_progress = 1'b0;
    drain(ok);
    total++; if (!ok || mon_data.size() != 1) begin
      bad++; $display("FAIL wait_count got=%0d exp=1", mon_data.size()); end
    else if (mon_data[0] !== 32'h04030201) begin
      bad++; $display("FAIL wait_final got=%h exp=04030201", mon_data[0]); end
  endtask

  task automatic test_overflow();
    bit ok;
    HRESETn = 1'b0; tick(); HRESETn = 1'b1; tick();
    clear_mon();
    in_progress = 1'b1; HREADY = 1'b0;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++)
        send_byte(32'h400 + 32'(w * 4 + b), 8'((w << 4) | b));
    tick();
    total++; if (s_overflow !== 1'b1) begin bad++; $display("FAIL ovf_d2 got=%b exp=1", s_overflow); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_d8 got=%b exp=0", overflow); end
    in_progress = 1'b0; HREADY = 1'b1;
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_drain got=timeout exp=idle"); end
    total++; if (s_addr.size() != 3) begin bad++; $display("FAIL ovf_count got=%0d exp=3", s_addr.size()); end
    else if (s_addr[0] !== 32'h400 || s_addr[1] !== 32'h404 || s_addr[2] !== 32'h408) begin
      bad++; $display("FAIL ovf_addrs got=%h,%h,%h exp=400,404,408", s_addr[0], s_addr[1], s_addr[2]); end
    total++; if (mon_data.size() != 4) begin bad++; $display("FAIL ovf_d8count got=%0d exp=4", mon_data.size()); end
    else if (mon_data[3] !== 32'h33323130) begin
      bad++; $display("FAIL ovf_d8last got=%h exp=33323130", mon_data[3]); end
    total++; if (s_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", s_overflow); end
  endtask

  task automatic test_errors();
    bit ok;
    logic [15:0] exp_err;
`ifdef MFP_SREC_AHB_ERRCNT_EN
    exp_err = 16'd3;
`else
    exp_err = 16'd0;
`endif
    HRESETn = 1'b0; tick(); HRESETn = 1'b1; tick();
    clear_mon();
    in_progress = 1'b1; HRESP = 1'b1;
    send_byte(32'h500, 8'h55); send_byte(32'h502, 8'h66); send_byte(32'h507, 8'h77);
    in_progress = 1'b0;
    drain(ok);
    HRESP = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL err_drain got=timeout exp=idle"); end
    total++; if (error_count !== exp_err) begin bad++; $display("FAIL err_count got=%0d exp=%0d", error_count, exp_err); end
    total++; if (mon_addr.size() != 3) begin bad++; $display("FAIL err_xfers got=%0d exp=3", mon_addr.size()); end
    else if (mon_addr[0] !== 32'h500 || mon_addr[1] !== 32'h502 || mon_addr[2] !== 32'h507 ||
             mon_data[2] !== 32'h77777777) begin
      bad++; $display("FAIL err_addrs got=%h,%h,%h/%h exp=500,502,507/77777777",
                      mon_addr[0], mon_addr[1], mon_addr[2], mon_data[2]); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    in_progress = 1'b1; HREADY = 1'b0;
    send_byte(32'h600, 8'h01); send_byte(32'h601, 8'h02);
    send_byte(32'h602, 8'h03); send_byte(32'h603, 8'h04);
    in_progress = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (HTRANS == 2'b10) begin seen = 1'b1; break; end
      tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL mid_nonseq got=timeout exp=nonseq"); end
    HRESETn = 1'b0;
    #1;
    total++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_async got=%h/%h/%b exp=0/0/0", HTRANS, HADDR, busy); end
    tick();
    HRESETn = 1'b1; HREADY = 1'b1;
    tick(); tick();
    total++; if (HTRANS !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_lost got=%h/%b exp=0/0", HTRANS, busy); end
  endtask

  initial begin
    test_reset();
    test_le_word();
    test_be_word();
    test_flush_bytes();
    test_wait_states();
    test_overflow();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
